// File: rtl/entropy_src_window_ctrl.sv
// Health-test window sequencer for the entropy source.
// Counts accepted raw samples per window, back-pressures the sampler while
// packed data drains, reports the window result to the main state machine,
// and meters packed words into the SHA3 conditioner or the bypass FIFO.
module entropy_src_window_ctrl #(
  parameter int RngBusWidth = 4,
  parameter int PackWidth   = 64,
  parameter int WinWidth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                bypass_mode_i,
  input  logic [WinWidth-1:0] window_i,
  input  logic                local_escalate_i,
  input  logic                sample_vld_i,
  output logic                sample_rdy_o,
  input  logic                ht_fail_i,
  input  logic                pack_vld_i,
  output logic                pack_pop_o,
  input  logic                sha3_start_i,
  input  logic                sha3_process_i,
  output logic                sha3_msg_vld_o,
  input  logic                sha3_msg_rdy_i,
  output logic                bypass_push_o,
  input  logic                bypass_rdy_i,
  output logic                ht_done_pulse_o,
  output logic                ht_fail_pulse_o,
  output logic [WinWidth-1:0] window_cnt_o,
  output logic                cfg_err_o,
  output logic                err_o
);

  // A window must hold a whole number of packed words.
  localparam int SamplesPerWord = PackWidth / RngBusWidth;
  localparam int WordLsbs       = $clog2(SamplesPerWord);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCollect = 3'd1,
    StDrain   = 3'd2,
    StReport  = 3'd3,
    StError   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [WinWidth-1:0] sample_cnt_q, sample_cnt_d;
  logic [WinWidth-1:0] window_q, window_d;
  logic [WinWidth-1:0] win_cnt_q, win_cnt_d;
  logic                bypass_q, bypass_d;
  logic                fail_q, fail_d;
  logic                absorb_q, absorb_d;
  logic                cfg_ok;
  logic                legal_run;
  logic                accept;

  function automatic logic [WinWidth-1:0] sat_inc(input logic [WinWidth-1:0] v);
    return (v == '1) ? v : v + WinWidth'(1);
  endfunction

  assign cfg_ok       = (window_i != '0) && (window_i[WordLsbs-1:0] == '0);
  assign legal_run    = (state_q == StIdle) || (state_q == StCollect) ||
                        (state_q == StDrain) || (state_q == StReport);
  assign accept       = sample_vld_i && sample_rdy_o;
  assign window_cnt_o = win_cnt_q;

  // Next-state, counters and all handshake outputs.
  always_comb begin
    state_d         = state_q;
    sample_cnt_d    = sample_cnt_q;
    window_d        = window_q;
    bypass_d        = bypass_q;
    fail_d          = fail_q;
    win_cnt_d       = win_cnt_q;
    sample_rdy_o    = 1'b0;
    pack_pop_o      = 1'b0;
    sha3_msg_vld_o  = 1'b0;
    bypass_push_o   = 1'b0;
    ht_done_pulse_o = 1'b0;
    ht_fail_pulse_o = 1'b0;
    cfg_err_o       = 1'b0;
    err_o           = 1'b0;

    case (state_q)
      StIdle: begin
        // Config is captured here and frozen for the whole run.
        window_d  = window_i;
        bypass_d  = bypass_mode_i;
        cfg_err_o = enable_i && !cfg_ok;
        if (enable_i && cfg_ok) state_d = StCollect;
      end
      StCollect: begin
        sample_rdy_o = 1'b1;
        fail_d       = fail_q | ht_fail_i;
        if (accept) begin
          if (sample_cnt_q == (window_q - WinWidth'(1))) begin
            sample_cnt_d = '0;
            state_d      = StDrain;
          end else begin
            sample_cnt_d = sample_cnt_q + WinWidth'(1);
          end
        end
      end
      StDrain: begin
        fail_d = fail_q | ht_fail_i;
        if (!pack_vld_i) state_d = StReport;
      end
      StReport: begin
        ht_done_pulse_o = enable_i;
        ht_fail_pulse_o = enable_i && fail_q;
        fail_d          = 1'b0;
        win_cnt_d       = sat_inc(win_cnt_q);
        state_d         = StCollect;
      end
      StError: begin
        err_o = 1'b1;
      end
      default: begin
        err_o   = 1'b1;
        state_d = StError;
      end
    endcase

    // Zero-latency forwarding of packed words while a window is running.
    if ((state_q == StCollect) || (state_q == StDrain)) begin
      if (bypass_q) begin
        bypass_push_o = pack_vld_i && bypass_rdy_i;
        pack_pop_o    = pack_vld_i && bypass_rdy_i;
      end else begin
        sha3_msg_vld_o = pack_vld_i && absorb_q;
        pack_pop_o     = pack_vld_i && absorb_q && sha3_msg_rdy_i;
      end
    end

    // Disable aborts the window silently; the completed-window count survives.
    if (!enable_i && legal_run) begin
      state_d      = StIdle;
      sample_cnt_d = '0;
      fail_d       = 1'b0;
      win_cnt_d    = win_cnt_q;
    end

    if (local_escalate_i) state_d = StError;
  end

  // Absorb window tracking: process beats start when both pulse together.
  always_comb begin
    absorb_d = absorb_q;
    if (sha3_start_i) absorb_d = 1'b1;
    if (sha3_process_i || !enable_i || !legal_run) absorb_d = 1'b0;
  end

  // State, counters and captured config.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      sample_cnt_q <= '0;
      window_q     <= '0;
      bypass_q     <= 1'b0;
      fail_q       <= 1'b0;
      absorb_q     <= 1'b0;
      win_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      window_q     <= window_d;
      bypass_q     <= bypass_d;
      fail_q       <= fail_d;
      absorb_q     <= absorb_d;
      win_cnt_q    <= win_cnt_d;
    end
  end

endmodule

// File: tb/tb_entropy_src_window_ctrl.sv
// Directed bench for entropy_src_window_ctrl. The bench plays the sample
// packer: every 16 accepted samples become one pending packed word.
module tb_entropy_src_window_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic        bypass_mode_i = 1'b0;
  logic [15:0] window_i = '0;
  logic        local_escalate_i = 1'b0;
  logic        sample_vld_i = 1'b0;
  logic        sample_rdy_o;
  logic        ht_fail_i = 1'b0;
  logic        pack_vld_i = 1'b0;
  logic        pack_pop_o;
  logic        sha3_start_i = 1'b0;
  logic        sha3_process_i = 1'b0;
  logic        sha3_msg_vld_o;
  logic        sha3_msg_rdy_i = 1'b0;
  logic        bypass_push_o;
  logic        bypass_rdy_i = 1'b0;
  logic        ht_done_pulse_o;
  logic        ht_fail_pulse_o;
  logic [15:0] window_cnt_o;
  logic        cfg_err_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int acc, acc_mod, pending, pops, sha3_xfer, byp_push, dones, ticks;
  logic [7:0] done_fail;

  entropy_src_window_ctrl #(.RngBusWidth(4), .PackWidth(64), .WinWidth(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .bypass_mode_i(bypass_mode_i),
    .window_i(window_i), .local_escalate_i(local_escalate_i),
    .sample_vld_i(sample_vld_i), .sample_rdy_o(sample_rdy_o), .ht_fail_i(ht_fail_i),
    .pack_vld_i(pack_vld_i), .pack_pop_o(pack_pop_o),
    .sha3_start_i(sha3_start_i), .sha3_process_i(sha3_process_i),
    .sha3_msg_vld_o(sha3_msg_vld_o), .sha3_msg_rdy_i(sha3_msg_rdy_i),
    .bypass_push_o(bypass_push_o), .bypass_rdy_i(bypass_rdy_i),
    .ht_done_pulse_o(ht_done_pulse_o), .ht_fail_pulse_o(ht_fail_pulse_o),
    .window_cnt_o(window_cnt_o), .cfg_err_o(cfg_err_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // One clock cycle: observe handshakes mid-cycle, then advance the packer model.
  task automatic tick();
    bit accepted, popped;
    pack_vld_i = (pending > 0);
    #2;
    accepted = sample_vld_i && sample_rdy_o;
    popped   = pack_pop_o;
    if (pack_pop_o) pops++;
    if (sha3_msg_vld_o && sha3_msg_rdy_i) sha3_xfer++;
    if (bypass_push_o) byp_push++;
    if (ht_done_pulse_o) begin
      if (dones < 8) done_fail[dones] = ht_fail_pulse_o;
      dones++;
    end
    @(posedge clk_i); #1;
    ticks++;
    if (popped) pending--;
    if (accepted) begin
      acc++;
      acc_mod++;
      if (acc_mod == 16) begin
        acc_mod = 0;
        pending++;
      end
    end
    pack_vld_i = (pending > 0);
  endtask

  task automatic clear_counts();
    acc = 0; pops = 0; sha3_xfer = 0; byp_push = 0; dones = 0; ticks = 0;
    done_fail = '0;
  endtask

  // Return to Idle, load a new config and enter Collect.
  task automatic restart(input logic [15:0] win, input logic byp);
    sample_vld_i = 1'b0;
    enable_i = 1'b0;
    tick();
    pending = 0; acc_mod = 0; pack_vld_i = 1'b0;
    window_i = win;
    bypass_mode_i = byp;
    enable_i = 1'b1;
    tick();
    clear_counts();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++; if ({sample_rdy_o, pack_pop_o, sha3_msg_vld_o, bypass_push_o} !== 4'b0) begin n_fail++; $display("FAIL reset_handshakes got=%b exp=0000", {sample_rdy_o, pack_pop_o, sha3_msg_vld_o, bypass_push_o}); end
    n_checks++; if ({ht_done_pulse_o, ht_fail_pulse_o, cfg_err_o, err_o} !== 4'b0) begin n_fail++; $display("FAIL reset_status got=%b exp=0000", {ht_done_pulse_o, ht_fail_pulse_o, cfg_err_o, err_o}); end
    n_checks++; if (window_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_window_cnt got=%0d exp=0", window_cnt_o); end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    pending = 0; acc_mod = 0;
    clear_counts();
  endtask

  task automatic test_sha3_window32();
    window_i = 16'd32;
    bypass_mode_i = 1'b0;
    sha3_msg_rdy_i = 1'b1;
    enable_i = 1'b1;
    #1;
    n_checks++; if (cfg_err_o !== 1'b0) begin n_fail++; $display("FAIL w32_cfg_err got=%b exp=0", cfg_err_o); end
    sha3_start_i = 1'b1;
    tick();
    sha3_start_i = 1'b0;
    clear_counts();
    sample_vld_i = 1'b1;
    for (int i = 0; i < 100 && acc < 32; i++) tick();
    sample_vld_i = 1'b0;
    n_checks++; if (acc !== 32) begin n_fail++; $display("FAIL w32_samples got=%0d exp=32", acc); end
    n_checks++; if (sample_rdy_o !== 1'b0) begin n_fail++; $display("FAIL w32_rdy_after_last got=%b exp=0", sample_rdy_o); end
    ticks = 0;
    for (int i = 0; i < 20 && dones < 1; i++) tick();
    n_checks++; if (ticks !== 3) begin n_fail++; $display("FAIL w32_done_latency got=%0d exp=3", ticks); end
    n_checks++; if (pops !== 2 || sha3_xfer !== 2) begin n_fail++; $display("FAIL w32_words got=%0d/%0d exp=2/2", pops, sha3_xfer); end
    n_checks++; if (dones !== 1 || done_fail[0] !== 1'b0) begin n_fail++; $display("FAIL w32_done got=%0d fail=%b exp=1 fail=0", dones, done_fail[0]); end
    n_checks++; if (window_cnt_o !== 16'd1) begin n_fail++; $display("FAIL w32_window_cnt got=%0d exp=1", window_cnt_o); end
    n_checks++; if (sample_rdy_o !== 1'b1) begin n_fail++; $display("FAIL w32_collect_resumes got=%b exp=1", sample_rdy_o); end
  endtask

  task automatic test_fail_window();
    bypass_rdy_i = 1'b1;
    restart(16'd16, 1'b1);
    sample_vld_i = 1'b1;
    for (int i = 0; i < 100 && dones < 2; i++) begin
      ht_fail_i = (acc == 15);
      tick();
    end
    ht_fail_i = 1'b0;
    sample_vld_i = 1'b0;
    n_checks++; if (dones !== 2 || acc !== 32) begin n_fail++; $display("FAIL fail_dones got=%0d acc=%0d exp=2 acc=32", dones, acc); end
    n_checks++; if (done_fail[1:0] !== 2'b01) begin n_fail++; $display("FAIL fail_pulses got=%b exp=01", done_fail[1:0]); end
    n_checks++; if (byp_push !== 2) begin n_fail++; $display("FAIL fail_bypass_push got=%0d exp=2", byp_push); end
    n_checks++; if (window_cnt_o !== 16'd3) begin n_fail++; $display("FAIL fail_window_cnt got=%0d exp=3", window_cnt_o); end
  endtask

  task automatic test_sha3_hold();
    sha3_msg_rdy_i = 1'b1;
    restart(16'd16, 1'b0);
    sample_vld_i = 1'b1;
    for (int i = 0; i < 100 && acc < 16; i++) tick();
    sample_vld_i = 1'b0;
    repeat (100) tick();
    n_checks++; if (dones !== 0 || pops !== 0 || sha3_xfer !== 0) begin n_fail++; $display("FAIL hold_no_progress got=%0d/%0d/%0d exp=0/0/0", dones, pops, sha3_xfer); end
    n_checks++; if (sample_rdy_o !== 1'b0 || sha3_msg_vld_o !== 1'b0) begin n_fail++; $display("FAIL hold_outputs got=%b%b exp=00", sample_rdy_o, sha3_msg_vld_o); end
    sha3_start_i = 1'b1;
    tick();
    sha3_start_i = 1'b0;
    for (int i = 0; i < 10 && dones < 1; i++) tick();
    n_checks++; if (pops !== 1 || sha3_xfer !== 1) begin n_fail++; $display("FAIL hold_forward got=%0d/%0d exp=1/1", pops, sha3_xfer); end
    n_checks++; if (dones !== 1 || done_fail[0] !== 1'b0) begin n_fail++; $display("FAIL hold_done got=%0d fail=%b exp=1 fail=0", dones, done_fail[0]); end
    n_checks++; if (window_cnt_o !== 16'd4) begin n_fail++; $display("FAIL hold_window_cnt got=%0d exp=4", window_cnt_o); end
  endtask

  task automatic test_bypass_backpressure();
    bypass_rdy_i = 1'b0;
    restart(16'd16, 1'b1);
    sample_vld_i = 1'b1;
    for (int i = 0; i < 100 && acc < 16; i++) tick();
    sample_vld_i = 1'b0;
    repeat (5) tick();
    n_checks++; if (pops !== 0 || byp_push !== 0 || dones !== 0) begin n_fail++; $display("FAIL byp_low got=%0d/%0d/%0d exp=0/0/0", pops, byp_push, dones); end
    bypass_rdy_i = 1'b1;
    tick();
    n_checks++; if (pops !== 1 || byp_push !== 1 || dones !== 0) begin n_fail++; $display("FAIL byp_pop got=%0d/%0d/%0d exp=1/1/0", pops, byp_push, dones); end
    tick();
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL byp_early_done got=%0d exp=0", dones); end
    tick();
    n_checks++; if (dones !== 1 || done_fail[0] !== 1'b0) begin n_fail++; $display("FAIL byp_done got=%0d fail=%b exp=1 fail=0", dones, done_fail[0]); end
    n_checks++; if (window_cnt_o !== 16'd5) begin n_fail++; $display("FAIL byp_window_cnt got=%0d exp=5", window_cnt_o); end
  endtask

  task automatic test_disable_abort();
    clear_counts();
    sample_vld_i = 1'b1;
    for (int i = 0; i < 100 && acc < 7; i++) tick();
    sample_vld_i = 1'b0;
    enable_i = 1'b0;
    tick();
    pending = 0; acc_mod = 0; pack_vld_i = 1'b0;
    enable_i = 1'b1;
    tick();
    n_checks++; if (dones !== 0 || window_cnt_o !== 16'd5) begin n_fail++; $display("FAIL abort_state got=%0d cnt=%0d exp=0 cnt=5", dones, window_cnt_o); end
    clear_counts();
    sample_vld_i = 1'b1;
    for (int i = 0; i < 100 && acc < 15; i++) tick();
    n_checks++; if (sample_rdy_o !== 1'b1 || dones !== 0) begin n_fail++; $display("FAIL abort_full_window got=%b dones=%0d exp=1 dones=0", sample_rdy_o, dones); end
    for (int i = 0; i < 20 && dones < 1; i++) tick();
    sample_vld_i = 1'b0;
    n_checks++; if (acc !== 16 || dones !== 1) begin n_fail++; $display("FAIL abort_refill got=%0d dones=%0d exp=16 dones=1", acc, dones); end
    n_checks++; if (window_cnt_o !== 16'd6) begin n_fail++; $display("FAIL abort_window_cnt got=%0d exp=6", window_cnt_o); end
  endtask

  task automatic test_cfg_err();
    sample_vld_i = 1'b0;
    enable_i = 1'b0;
    tick();
    window_i = 16'd20;
    enable_i = 1'b1;
    #1;
    n_checks++; if (cfg_err_o !== 1'b1) begin n_fail++; $display("FAIL cfg_w20 got=%b exp=1", cfg_err_o); end
    tick();
    tick();
    n_checks++; if (cfg_err_o !== 1'b1 || sample_rdy_o !== 1'b0) begin n_fail++; $display("FAIL cfg_stays_idle got=%b%b exp=10", cfg_err_o, sample_rdy_o); end
    window_i = 16'd0;
    #1;
    n_checks++; if (cfg_err_o !== 1'b1) begin n_fail++; $display("FAIL cfg_w0 got=%b exp=1", cfg_err_o); end
    window_i = 16'd16;
    #1;
    n_checks++; if (cfg_err_o !== 1'b0) begin n_fail++; $display("FAIL cfg_w16 got=%b exp=0", cfg_err_o); end
    tick();
    n_checks++; if (sample_rdy_o !== 1'b1) begin n_fail++; $display("FAIL cfg_enter_collect got=%b exp=1", sample_rdy_o); end
  endtask

  task automatic test_escalate();
    sha3_msg_rdy_i = 1'b1;
    restart(16'd16, 1'b0);
    sample_vld_i = 1'b1;
    for (int i = 0; i < 100 && acc < 16; i++) tick();
    sample_vld_i = 1'b0;
    tick();
    tick();
    local_escalate_i = 1'b1;
    tick();
    local_escalate_i = 1'b0;
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL esc_err got=%b exp=1", err_o); end
    sha3_start_i = 1'b1;
    sample_vld_i = 1'b1;
    bypass_rdy_i = 1'b1;
    tick();
    sha3_start_i = 1'b0;
    repeat (3) tick();
    n_checks++; if ({sample_rdy_o, pack_pop_o, sha3_msg_vld_o, bypass_push_o, ht_done_pulse_o} !== 5'b0) begin n_fail++; $display("FAIL esc_handshakes got=%b exp=00000", {sample_rdy_o, pack_pop_o, sha3_msg_vld_o, bypass_push_o, ht_done_pulse_o}); end
    n_checks++; if (pops !== 0 || dones !== 0) begin n_fail++; $display("FAIL esc_activity got=%0d/%0d exp=0/0", pops, dones); end
    sample_vld_i = 1'b0;
    enable_i = 1'b0;
    tick();
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL esc_sticky got=%b exp=1", err_o); end
    rst_ni = 1'b0;
    #1;
    n_checks++; if (err_o !== 1'b0 || window_cnt_o !== 16'd0) begin n_fail++; $display("FAIL esc_reset got=%b cnt=%0d exp=0 cnt=0", err_o, window_cnt_o); end
    rst_ni = 1'b1;
  endtask

  initial begin
    pending = 0; acc_mod = 0;
    clear_counts();
    test_reset();
    test_sha3_window32();
    test_fail_window();
    test_sha3_hold();
    test_bypass_backpressure();
    test_disable_abort();
    test_cfg_err();
    test_escalate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the end of test");
    $fatal(1, "watchdog");
  end

endmodule
